gray_fifo_ctrl: RTL and testbench

GRAY_FIFO_CTRL -- requirements
Module: gray_fifo_ctrl

---
 rtl/gray_fifo_ctrl_if.sv | 32 +++
 rtl/gray_fifo_ctrl.sv | 83 ++++++++
 tb/tb_gray_fifo_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/gray_fifo_ctrl_if.sv
// Handshake and status bundle for the Gray-pointer FIFO controller.
// The master side is the requester. The slave side is the controller.
interface gray_fifo_ctrl_if #(
  parameter int AW = 4
);
  logic          flush;
  logic          wr_req;
  logic          rd_req;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   wr_ptr_gray;
  logic [AW:0]   rd_ptr_gray;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  modport master (
    output flush, wr_req, rd_req,
    input  wr_en, wr_addr, rd_en, rd_addr, wr_ptr_gray, rd_ptr_gray,
           full, empty, count, overflow, underflow
  );

  modport slave (
    input  flush, wr_req, rd_req,
    output wr_en, wr_addr, rd_en, rd_addr, wr_ptr_gray, rd_ptr_gray,
           full, empty, count, overflow, underflow
  );
endinterface

// File: rtl/gray_fifo_ctrl.sv
// FIFO pointer/flag controller with registered Gray-coded pointers.
// Each pointer is AW+1 bits wide. The extra MSB tells full apart from empty.
// The flags and the Gray codes are computed from the next-state pointers.
// As a result, every registered output changes one cycle after the accepted strobe.
module gray_fifo_ctrl #(
  parameter int AW = 4
) (
  input  logic            clk,
  input  logic            rst,
  gray_fifo_ctrl_if.slave bus
);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] wr_gray_q, wr_gray_d;
  logic [AW:0] rd_gray_q, rd_gray_d;
  logic [AW:0] count_q, count_d;
  logic        full_q, full_d;
  logic        empty_q, empty_d;
  logic        overflow_q, overflow_d;
  logic        underflow_q, underflow_d;
  logic        wr_en, rd_en;

  // Storage strobes: these are gated by the registered flags; a flush blocks both.
  assign wr_en = bus.wr_req & ~full_q  & ~bus.flush;
  assign rd_en = bus.rd_req & ~empty_q & ~bus.flush;

  // Next-state pointers, flags and error pulses, all derived from the same next pointers.
  always_comb begin
    wr_ptr_d    = wr_ptr_q + {{AW{1'b0}}, wr_en};
    rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, rd_en};
    overflow_d  = bus.wr_req & full_q  & ~bus.flush;
    underflow_d = bus.rd_req & empty_q & ~bus.flush;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
    wr_gray_d = wr_ptr_d ^ (wr_ptr_d >> 1);
    rd_gray_d = rd_ptr_d ^ (rd_ptr_d >> 1);
    empty_d   = (wr_ptr_d == rd_ptr_d);
    full_d    = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    count_d   = wr_ptr_d - rd_ptr_d;
  end

  // State register; reset takes priority over flush and requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      wr_gray_q   <= '0;
      rd_gray_q   <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_gray_q   <= wr_gray_d;
      rd_gray_q   <= rd_gray_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.wr_en       = wr_en;
  assign bus.rd_en       = rd_en;
  assign bus.wr_addr     = wr_ptr_q[AW-1:0];
  assign bus.rd_addr     = rd_ptr_q[AW-1:0];
  assign bus.wr_ptr_gray = wr_gray_q;
  assign bus.rd_ptr_gray = rd_gray_q;
  assign bus.count       = count_q;
  assign bus.full        = full_q;
  assign bus.empty       = empty_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;

endmodule

// File: tb/tb_gray_fifo_ctrl.sv
// Self-checking bench for gray_fifo_ctrl.
// The run has two parts: directed scenarios, then randomized traffic.
// A reference model tracks occupancy and the pointer positions as plain integers.
module tb_gray_fifo_ctrl;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int PMOD  = 1 << (AW + 1);

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  int wp, rp, occ;
  bit e_ovf, e_unf;

  gray_fifo_ctrl_if #(.AW(AW)) bus ();

  gray_fifo_ctrl #(.AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic int gray_of(input int p);
    return p ^ (p >> 1);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Runs one clock cycle. It applies the inputs, checks the strobes before the edge,
  // then checks the registered outputs after the edge.
  task automatic step(input bit wr, input bit rd, input bit fl, input bit rs);
    bit push, pop;
    logic [AW:0] prev_wg, prev_rg;
    int old_wp, old_rp;
    bus.wr_req = wr;
    bus.rd_req = rd;
    bus.flush  = fl;
    rst        = rs;
    #1;
    push = wr && (occ < DEPTH) && !fl;
    pop  = rd && (occ > 0) && !fl;
    check_eq("wr_en",   bus.wr_en, push);
    check_eq("rd_en",   bus.rd_en, pop);
    check_eq("wr_addr", bus.wr_addr, wp % DEPTH);
    check_eq("rd_addr", bus.rd_addr, rp % DEPTH);
    prev_wg = bus.wr_ptr_gray;
    prev_rg = bus.rd_ptr_gray;
    old_wp = wp;
    old_rp = rp;
    @(posedge clk);
    if (rs || fl) begin
      wp = 0; rp = 0; occ = 0; e_ovf = 0; e_unf = 0;
    end else begin
      e_ovf = wr && (occ == DEPTH);
      e_unf = rd && (occ == 0);
      if (push) wp = (wp + 1) % PMOD;
      if (pop)  rp = (rp + 1) % PMOD;
      occ = occ + int'(push) - int'(pop);
    end
    @(negedge clk);
    check_eq("count",     bus.count, occ);
    check_eq("full",      bus.full, occ == DEPTH);
    check_eq("empty",     bus.empty, occ == 0);
    check_eq("overflow",  bus.overflow, e_ovf);
    check_eq("underflow", bus.underflow, e_unf);
    check_eq("wr_gray",   bus.wr_ptr_gray, gray_of(wp));
    check_eq("rd_gray",   bus.rd_ptr_gray, gray_of(rp));
    if (!rs && !fl && push && wp == (old_wp + 1) % PMOD)
      check_eq("wr_gray_1bit", $countones(bus.wr_ptr_gray ^ prev_wg), 1);
    if (!rs && !fl && pop && rp == (old_rp + 1) % PMOD)
      check_eq("rd_gray_1bit", $countones(bus.rd_ptr_gray ^ prev_rg), 1);
  endtask

  initial begin
    bit wr, rd, fl, rs;
    int pct;
    wp = 0; rp = 0; occ = 0; e_ovf = 0; e_unf = 0;
    bus.wr_req = 1'b0; bus.rd_req = 1'b0; bus.flush = 1'b0; rst = 1'b1;
    @(negedge clk);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // Fill the FIFO with 16 pushes.
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0);
    check_eq("gray16", bus.wr_ptr_gray, 5'b11000);
    // Push while full: expect an overflow pulse and no pointer change.
    step(1, 0, 0, 0);
    check_eq("gray_hold", bus.wr_ptr_gray, 5'b11000);
    // Push and pop together while full: the pop is accepted and overflow pulses.
    step(1, 1, 0, 0);
    check_eq("rd_gray_1", bus.rd_ptr_gray, 5'b00001);
    // Drain to 3 entries, then stream long enough for both pointers to wrap.
    for (int i = 0; i < 12; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 40; i++) step(1, 1, 0, 0);
    // Drain completely, then pop while empty to get an underflow pulse.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    // Load 7 entries, then flush.
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0);
    step(1, 1, 1, 0);
    // Load 9 entries, then reset while a push is requested.
    for (int i = 0; i < 9; i++) step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    // Reset together with flush and both requests.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    step(1, 1, 1, 1);

    // Randomized traffic. The push/pop bias alternates so that both full and empty are reached.
    for (int i = 0; i < 1500; i++) begin
      pct = ((i / 100) % 2) ? 75 : 25;
      wr = ($urandom_range(99) < pct);
      rd = ($urandom_range(99) < (100 - pct));
      fl = ($urandom_range(47) == 0);
      rs = ($urandom_range(199) == 0);
      step(wr, rd, fl, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
